// File: rtl/hwpe_multi_stream_kernel_adapter.sv
// -----------------------------------------------------------------------------
// hwpe_multi_stream_kernel_adapter
//
// Glue between the HWPE streamer and an accelerated kernel that has several
// input (sink) and output (source) streams. Each job carries a per-channel
// beat quota. The adapter counts handshakes against those quotas, closes an
// input stream once its quota is consumed, and reports progress to the engine
// FSM through ready/done/idle flags. Data and handshakes pass through
// combinationally; only the counters, gating state and flags are registered.
//
// Parameters:
//   N_IN    number of input (sink) channels, 1..8
//   N_OUT   number of output (source) channels, 1..8
//   DATA_W  data width per channel
//   CNT_W   width of quotas and beat counters
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   test_mode_i                   unused, kept for wrapper compatibility
//   start_i                       job start pulse from the engine FSM
//   in_quota_i / out_quota_i      per-channel beat quotas, latched at start
//   in_valid_i/in_ready_o/in_data_i          streamer-side sinks
//   k_in_valid_o/k_in_ready_i/k_in_data_o    kernel-side inputs
//   k_out_valid_i/k_out_ready_o/k_out_data_i kernel-side outputs
//   out_valid_o/out_ready_i/out_data_o       streamer-side sources
//   ready_o                       all input quotas consumed (level, RUN only)
//   done_o                        one-cycle pulse when all output quotas met
//   idle_o                        no job active
//   out_done_o                    per-output one-cycle pulse on quota met
// -----------------------------------------------------------------------------
module hwpe_multi_stream_kernel_adapter #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 1,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    test_mode_i,
    input  logic                    start_i,
    input  logic [N_IN*CNT_W-1:0]   in_quota_i,
    input  logic [N_OUT*CNT_W-1:0]  out_quota_i,
    input  logic [N_IN-1:0]         in_valid_i,
    output logic [N_IN-1:0]         in_ready_o,
    input  logic [N_IN*DATA_W-1:0]  in_data_i,
    output logic [N_IN-1:0]         k_in_valid_o,
    input  logic [N_IN-1:0]         k_in_ready_i,
    output logic [N_IN*DATA_W-1:0]  k_in_data_o,
    input  logic [N_OUT-1:0]        k_out_valid_i,
    output logic [N_OUT-1:0]        k_out_ready_o,
    input  logic [N_OUT*DATA_W-1:0] k_out_data_i,
    output logic [N_OUT-1:0]        out_valid_o,
    input  logic [N_OUT-1:0]        out_ready_i,
    output logic [N_OUT*DATA_W-1:0] out_data_o,
    output logic                    ready_o,
    output logic                    done_o,
    output logic                    idle_o,
    output logic [N_OUT-1:0]        out_done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] in_q_q    [N_IN];
    logic [CNT_W-1:0] in_q_d    [N_IN];
    logic [CNT_W-1:0] in_cnt_q  [N_IN];
    logic [CNT_W-1:0] in_cnt_d  [N_IN];
    logic [CNT_W-1:0] out_q_q   [N_OUT];
    logic [CNT_W-1:0] out_q_d   [N_OUT];
    logic [CNT_W-1:0] out_cnt_q [N_OUT];
    logic [CNT_W-1:0] out_cnt_d [N_OUT];

    logic [N_IN-1:0]  in_open;
    logic [N_IN-1:0]  in_fire;
    logic [N_OUT-1:0] out_fire;

    logic [N_OUT-1:0] out_seen_q, out_seen_d;
    logic [N_OUT-1:0] out_done_d, out_done_q;
    logic             all_in_met, all_out_met;
    logic             ready_d, ready_q, done_q, idle_q;

    logic unused_test_mode;
    assign unused_test_mode = test_mode_i;

    // An input channel is open only while a job runs and it still owes beats.
    // A zero quota therefore keeps the channel closed for the whole job.
    always_comb begin
        in_open = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_open[i] = (state_q == RUN) && (in_cnt_q[i] < in_q_q[i]);
        end
    end

    assign k_in_valid_o = in_valid_i & in_open;
    assign in_ready_o   = k_in_ready_i & in_open;
    assign k_in_data_o  = in_data_i;
    assign in_fire      = in_valid_i & in_ready_o;

    assign out_valid_o   = k_out_valid_i;
    assign k_out_ready_o = out_ready_i;
    assign out_data_o    = k_out_data_i;
    assign out_fire      = out_valid_o & out_ready_i;

    // Next-state logic. Completion is judged on the counter values that will
    // hold after this edge, so the FINISH cycle (done_o) and the per-channel
    // out_done_o pulses land one cycle after the final handshake rather than
    // two. A start seen in FINISH chains straight into the next job.
    always_comb begin
        state_d     = state_q;
        in_q_d      = in_q_q;
        out_q_d     = out_q_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        out_seen_d  = out_seen_q;
        out_done_d  = '0;
        all_out_met = 1'b1;
        all_in_met  = 1'b1;

        case (state_q)
            RUN: begin
                for (int i = 0; i < N_IN; i++) begin
                    if (in_fire[i] && (in_cnt_q[i] < in_q_q[i])) begin
                        in_cnt_d[i] = in_cnt_q[i] + CNT_W'(1);
                    end
                end
                for (int j = 0; j < N_OUT; j++) begin
                    if (out_fire[j] && (out_cnt_q[j] < out_q_q[j])) begin
                        out_cnt_d[j] = out_cnt_q[j] + CNT_W'(1);
                    end
                end
                for (int j = 0; j < N_OUT; j++) begin
                    if (out_cnt_d[j] != out_q_q[j]) begin
                        all_out_met = 1'b0;
                    end else if (!out_seen_q[j]) begin
                        out_done_d[j] = 1'b1;
                        out_seen_d[j] = 1'b1;
                    end
                end
                if (all_out_met) begin
                    state_d = FINISH;
                end
            end
            IDLE, FINISH: begin
                if (start_i) begin
                    state_d    = RUN;
                    out_seen_d = '0;
                    for (int i = 0; i < N_IN; i++) begin
                        in_q_d[i]   = in_quota_i[i*CNT_W +: CNT_W];
                        in_cnt_d[i] = '0;
                    end
                    for (int j = 0; j < N_OUT; j++) begin
                        out_q_d[j]   = out_quota_i[j*CNT_W +: CNT_W];
                        out_cnt_d[j] = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        for (int i = 0; i < N_IN; i++) begin
            if (in_cnt_d[i] != in_q_d[i]) begin
                all_in_met = 1'b0;
            end
        end
        ready_d = (state_d == RUN) && all_in_met;
    end

    // State, quota and counter registers plus the registered flags. Flags are
    // derived from the next state so they line up with the state they report.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            for (int i = 0; i < N_IN; i++) begin
                in_q_q[i]   <= '0;
                in_cnt_q[i] <= '0;
            end
            for (int j = 0; j < N_OUT; j++) begin
                out_q_q[j]   <= '0;
                out_cnt_q[j] <= '0;
            end
            out_seen_q <= '0;
            out_done_q <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_q_q     <= in_q_d;
            in_cnt_q   <= in_cnt_d;
            out_q_q    <= out_q_d;
            out_cnt_q  <= out_cnt_d;
            out_seen_q <= out_seen_d;
            out_done_q <= out_done_d;
            ready_q    <= ready_d;
            done_q     <= (state_d == FINISH);
            idle_q     <= (state_d == IDLE);
        end
    end

    assign ready_o    = ready_q;
    assign done_o     = done_q;
    assign idle_o     = idle_q;
    assign out_done_o = out_done_q;

endmodule

// File: tb/tb_hwpe_multi_stream_kernel_adapter.sv
// -----------------------------------------------------------------------------
// tb_hwpe_multi_stream_kernel_adapter
//
// Self-checking bench for the multi-stream kernel adapter with two input
// channels and one output channel. A reference model tracks, per job, how
// many beats each channel still owes and whether a job is running or in its
// completion cycle; every cycle the DUT outputs are compared against it.
// A hand-derived vector table covers the basic job, and short directed
// sequences cover gating, back-to-back jobs, zero quotas, ignored starts and
// reset mid-job, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_hwpe_multi_stream_kernel_adapter;

    localparam int NI = 2;
    localparam int NO = 1;
    localparam int DW = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, test_mode, start;
    logic [NI*CW-1:0]  in_quota;
    logic [NO*CW-1:0]  out_quota;
    logic [NI-1:0]     in_valid, in_ready, k_in_valid, k_in_ready;
    logic [NI*DW-1:0]  in_data, k_in_data;
    logic [NO-1:0]     k_out_valid, k_out_ready, out_valid, out_ready, out_done;
    logic [NO*DW-1:0]  k_out_data, out_data;
    logic              ready, done, idle;

    hwpe_multi_stream_kernel_adapter #(
        .N_IN(NI), .N_OUT(NO), .DATA_W(DW), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .test_mode_i(test_mode), .start_i(start),
        .in_quota_i(in_quota), .out_quota_i(out_quota),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .k_in_valid_o(k_in_valid), .k_in_ready_i(k_in_ready), .k_in_data_o(k_in_data),
        .k_out_valid_i(k_out_valid), .k_out_ready_o(k_out_ready), .k_out_data_i(k_out_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .ready_o(ready), .done_o(done), .idle_o(idle), .out_done_o(out_done)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Reference model: beats still owed per channel, job phase flags.
    bit          job_running, job_closing, m_ready;
    int          in_left  [NI];
    int          out_left [NO];
    bit          out_reported [NO];
    logic [NO-1:0] m_out_done;

    int done_seen, kin0_hs, idle_ones;

    typedef struct {
        logic       start;
        logic       kov;
        logic       exp_idle;
        logic       exp_ready;
        logic       exp_done;
        logic       exp_out_done;
        logic [1:0] exp_kiv;
        logic [1:0] exp_ir;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        job_running = 0; job_closing = 0; m_ready = 0; m_out_done = '0;
        for (int i = 0; i < NI; i++) in_left[i] = 0;
        for (int j = 0; j < NO; j++) begin out_left[j] = 0; out_reported[j] = 0; end
    endtask

    // Advance the model by one clock edge using the inputs held this cycle.
    task automatic model_update();
        bit job_complete;
        if (rst) begin
            model_reset();
        end else begin
            m_out_done = '0;
            if (job_running) begin
                for (int i = 0; i < NI; i++)
                    if (in_valid[i] && k_in_ready[i] && in_left[i] > 0) in_left[i]--;
                for (int j = 0; j < NO; j++)
                    if (k_out_valid[j] && out_ready[j] && out_left[j] > 0) out_left[j]--;
                job_complete = 1;
                for (int j = 0; j < NO; j++) begin
                    if (out_left[j] != 0) job_complete = 0;
                    else if (!out_reported[j]) begin
                        m_out_done[j] = 1'b1;
                        out_reported[j] = 1;
                    end
                end
                if (job_complete) begin
                    job_running = 0;
                    job_closing = 1;
                end
            end else if (start) begin
                job_running = 1;
                job_closing = 0;
                for (int i = 0; i < NI; i++) in_left[i] = int'(in_quota[i*CW +: CW]);
                for (int j = 0; j < NO; j++) begin
                    out_left[j] = int'(out_quota[j*CW +: CW]);
                    out_reported[j] = 0;
                end
            end else begin
                job_closing = 0;
            end
            m_ready = job_running;
            for (int i = 0; i < NI; i++) if (in_left[i] != 0) m_ready = 0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic [1:0] iv,
                                 input logic [1:0] kir, input logic kov, input logic ordy);
        rst         = r;
        start       = s;
        in_valid    = iv;
        k_in_ready  = kir;
        k_out_valid = kov;
        out_ready   = ordy;
        in_data     = {$urandom, $urandom};
        k_out_data  = $urandom;
    endtask

    task automatic checkOutput(input string tag);
        logic [1:0] ekiv, eir;
        for (int i = 0; i < NI; i++) begin
            ekiv[i] = in_valid[i] && job_running && (in_left[i] > 0);
            eir[i]  = k_in_ready[i] && job_running && (in_left[i] > 0);
        end
        check({tag, ".idle"},      idle,       !(job_running || job_closing));
        check({tag, ".ready"},     ready,      m_ready);
        check({tag, ".done"},      done,       job_closing);
        check({tag, ".out_done"},  out_done,   m_out_done);
        check({tag, ".k_in_valid"},k_in_valid, ekiv);
        check({tag, ".in_ready"},  in_ready,   eir);
        check({tag, ".k_in_data"}, k_in_data,  in_data);
        check({tag, ".out_valid"}, out_valid,  k_out_valid);
        check({tag, ".k_out_rdy"}, k_out_ready,out_ready);
        check({tag, ".out_data"},  out_data,   k_out_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Compare against the model, log DUT events, then advance one cycle.
    task automatic run_cycle(input string tag);
        #1;
        checkOutput(tag);
        if (done) done_seen++;
        if (k_in_valid[0] && k_in_ready[0]) kin0_hs++;
        if (idle) idle_ones++;
        tick();
    endtask

    initial begin
        int done_at;

        // Basic job: in_q = {ch1:1, ch0:4}, out_q = 4, kernel output lags by one cycle.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};

        test_mode = 1'b0;
        in_quota  = '0;
        out_quota = '0;
        model_reset();

        // Reset
        applyStimulus(1, 0, 2'b11, 2'b11, 1, 1);
        tick();
        run_cycle("reset");

        // Basic job from the vector table
        in_quota  = {16'd1, 16'd4};
        out_quota = 16'd4;
        for (int r = 0; r < 8; r++) begin
            applyStimulus(0, tbl[r].start, 2'b11, 2'b11, tbl[r].kov, 1);
            #1;
            check($sformatf("tbl%0d.idle", r),       idle,       tbl[r].exp_idle);
            check($sformatf("tbl%0d.ready", r),      ready,      tbl[r].exp_ready);
            check($sformatf("tbl%0d.done", r),       done,       tbl[r].exp_done);
            check($sformatf("tbl%0d.out_done", r),   out_done,   tbl[r].exp_out_done);
            check($sformatf("tbl%0d.k_in_valid", r), k_in_valid, tbl[r].exp_kiv);
            check($sformatf("tbl%0d.in_ready", r),   in_ready,   tbl[r].exp_ir);
            tick();
        end

        // Gating: ch0 quota 3 with valid held high, ch1 closed
        in_quota  = {16'd0, 16'd3};
        out_quota = 16'd1;
        kin0_hs = 0;
        applyStimulus(0, 1, 2'b11, 2'b11, 0, 1);
        run_cycle("gate");
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, 0, 2'b11, 2'b11, 0, 1);
            run_cycle("gate");
        end
        applyStimulus(0, 0, 2'b11, 2'b11, 1, 1);
        #1;
        check("gate.in_ready0_closed", in_ready[0], 1'b0);
        run_cycle("gate");
        for (int c = 0; c < 2; c++) begin
            applyStimulus(0, 0, 2'b11, 2'b11, 0, 1);
            run_cycle("gate");
        end
        check("gate.kin0_handshakes", kin0_hs, 3);

        // Back-to-back: start again during FINISH with new quotas
        in_quota  = {16'd1, 16'd1};
        out_quota = 16'd1;
        done_seen = 0;
        idle_ones = 0;
        applyStimulus(0, 1, 2'b11, 2'b11, 1, 1);
        run_cycle("b2b");
        idle_ones = 0;
        applyStimulus(0, 0, 2'b11, 2'b11, 1, 1);
        run_cycle("b2b");
        in_quota  = {16'd2, 16'd2};
        out_quota = 16'd2;
        applyStimulus(0, 1, 2'b11, 2'b11, 1, 1);
        run_cycle("b2b");
        applyStimulus(0, 0, 2'b11, 2'b11, 1, 1);
        #1;
        check("b2b.restart_open", k_in_valid, 2'b11);
        run_cycle("b2b");
        for (int c = 0; c < 2; c++) begin
            applyStimulus(0, 0, 2'b11, 2'b11, 1, 1);
            run_cycle("b2b");
        end
        check("b2b.idle_stayed_low", idle_ones, 0);
        applyStimulus(0, 0, 2'b00, 2'b00, 0, 1);
        run_cycle("b2b");
        check("b2b.done_count", done_seen, 2);

        // Zero quotas: done two cycles after start
        in_quota  = '0;
        out_quota = '0;
        done_at = -1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, k == 0, 2'b11, 2'b11, 1, 1);
            #1;
            if (done && done_at < 0) done_at = k;
            run_cycle("zero");
        end
        check("zero.done_latency", done_at, 2);

        // Start pulsed during RUN is ignored
        in_quota  = {16'd3, 16'd3};
        out_quota = 16'd3;
        done_at = -1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, (k == 0) || (k == 2), 2'b11, 2'b11, 1, 1);
            #1;
            if (done && done_at < 0) done_at = k;
            run_cycle("ign");
        end
        check("ign.done_latency", done_at, 4);

        // Reset after 2 of 5 beats
        in_quota  = {16'd5, 16'd5};
        out_quota = 16'd5;
        applyStimulus(0, 1, 2'b11, 2'b11, 1, 1);
        run_cycle("rstmid");
        for (int c = 0; c < 2; c++) begin
            applyStimulus(0, 0, 2'b11, 2'b11, 1, 1);
            run_cycle("rstmid");
        end
        applyStimulus(1, 0, 2'b11, 2'b11, 1, 1);
        run_cycle("rstmid");
        applyStimulus(0, 0, 2'b11, 2'b11, 1, 1);
        #1;
        check("rstmid.idle", idle, 1'b1);
        check("rstmid.ready", ready, 1'b0);
        check("rstmid.in_ready", in_ready, 2'b00);
        run_cycle("rstmid");

        // Backpressure: out_q = 10 with random out_ready
        in_quota  = {16'($urandom_range(0, 5)), 16'($urandom_range(0, 5))};
        out_quota = 16'd10;
        done_seen = 0;
        applyStimulus(0, 1, 2'b11, 2'b11, 1, 1);
        run_cycle("bp");
        for (int c = 0; c < 300; c++) begin
            applyStimulus(0, 0, 2'($urandom), 2'($urandom),
                          $urandom_range(0, 3) != 0, 1'($urandom));
            run_cycle("bp");
            if (done_seen > 0) break;
        end
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 0, 2'($urandom), 2'($urandom), 1, 1);
            run_cycle("bp");
        end
        check("bp.done_count", done_seen, 1);

        // Randomized traffic, random starts and occasional reset
        for (int c = 0; c < 800; c++) begin
            in_quota  = {16'($urandom_range(0, 7)), 16'($urandom_range(0, 7))};
            out_quota = 16'($urandom_range(0, 7));
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0,
                          2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
            run_cycle("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
